// File: rtl/mem_arbiter.sv
// Two-requester data-memory arbiter: pipeline port vs debug port, one access in flight.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise the CPU always wins ties.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_size,
  input  logic        dbg_req,
  input  logic        dbg_wr,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [2:0]  dbg_size,
  output logic        cpu_done,
  output logic        dbg_done,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    DBG_ACC,
    RESP
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic        own_dbg_q, own_dbg_d;
  logic        pick_dbg;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dbg_q, last_dbg_d;

  // On a tie, grant whoever did not win the previous grant.
  assign pick_dbg = dbg_req & (~cpu_req | ~last_dbg_q);

  always_comb begin
    last_dbg_d = last_dbg_q;
    if (state_q == IDLE && (cpu_req | dbg_req)) begin
      last_dbg_d = pick_dbg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dbg_q <= 1'b1;
    end else begin
      last_dbg_q <= last_dbg_d;
    end
  end
`else
  assign pick_dbg = dbg_req & ~cpu_req;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    own_dbg_d = own_dbg_q;
    cpu_done  = 1'b0;
    dbg_done  = 1'b0;
    rdata     = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req | dbg_req) begin
          state_d   = pick_dbg ? DBG_ACC : CPU_ACC;
          cnt_d     = '0;
          own_dbg_d = pick_dbg;
          wr_d      = pick_dbg ? dbg_wr : cpu_wr;
          addr_d    = pick_dbg ? dbg_addr : cpu_addr;
          wdata_d   = pick_dbg ? dbg_wdata : cpu_wdata;
          size_d    = pick_dbg ? dbg_size : cpu_size;
        end
      end
      CPU_ACC, DBG_ACC: begin
        mem_wr_en = (cnt_q == 4'd0) & wr_q;
        mem_rd_en = (cnt_q == 4'd0) & ~wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_size  = size_q;
        if (cnt_q == LAT_M1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        cpu_done = ~own_dbg_q;
        dbg_done = own_dbg_q;
        rdata    = wr_q ? 32'd0 : mem_rdata;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = cpu_req & ~cpu_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      own_dbg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      own_dbg_q <= own_dbg_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: u1 runs MEM_LAT=1, u3 runs MEM_LAT=3 on shared inputs.
// Tie-break expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr, dbg_req, dbg_wr;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic [2:0]  cpu_size, dbg_size;

  logic        o1_cpu_done, o1_dbg_done, o1_stall, o1_wr_en, o1_rd_en;
  logic [31:0] o1_rdata, o1_addr, o1_wdata;
  logic [2:0]  o1_size;
  logic        o3_cpu_done, o3_dbg_done, o3_stall, o3_wr_en, o3_rd_en;
  logic [31:0] o3_rdata, o3_addr, o3_wdata;
  logic [2:0]  o3_size;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_size(dbg_size),
    .cpu_done(o1_cpu_done), .dbg_done(o1_dbg_done), .rdata(o1_rdata),
    .stall(o1_stall), .mem_wr_en(o1_wr_en), .mem_rd_en(o1_rd_en),
    .mem_addr(o1_addr), .mem_wdata(o1_wdata), .mem_size(o1_size),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_size(dbg_size),
    .cpu_done(o3_cpu_done), .dbg_done(o3_dbg_done), .rdata(o3_rdata),
    .stall(o3_stall), .mem_wr_en(o3_wr_en), .mem_rd_en(o3_rd_en),
    .mem_addr(o3_addr), .mem_wdata(o3_wdata), .mem_size(o3_size),
    .mem_rdata(mem_rdata)
  );

  task automatic clear_inputs();
    cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_size = 0;
    dbg_req = 0; dbg_wr = 0; dbg_addr = 0; dbg_wdata = 0; dbg_size = 0;
    mem_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    cpu_req = 1;
    #1;
    checks++;
    if ({o1_cpu_done, o1_dbg_done, o1_wr_en, o1_rd_en, o1_stall} !== 5'b00001 ||
        o1_addr !== 0 || o1_wdata !== 0 || o1_size !== 0 || o1_rdata !== 0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h size=%h rdata=%h, required ctl=00001 rest 0",
               {o1_cpu_done, o1_dbg_done, o1_wr_en, o1_rd_en, o1_stall},
               o1_addr, o1_wdata, o1_size, o1_rdata);
    end
    cpu_req = 0;
    #1;
    checks++;
    if (o1_stall !== 1'b0 || o3_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_low: got %b/%b required 0/0", o1_stall, o3_stall);
    end
    do_reset();
  endtask

  task automatic test_cpu_load();
    logic [2:0] exp;
    do_reset();
    next_cycle();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10; cpu_size = 3'd2;
    mem_rdata = 32'hCAFEF00D;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      exp = {c == 1, c == 2, c < 2};
      checks++;
      if ({o1_rd_en, o1_cpu_done, o1_stall} !== exp || o1_wr_en !== 1'b0 || o1_dbg_done !== 1'b0) begin
        errors++;
        $display("FAIL cpu_load_c%0d: rd/done/stall=%b wr=%b dd=%b required %b wr=0 dd=0",
                 c, {o1_rd_en, o1_cpu_done, o1_stall}, o1_wr_en, o1_dbg_done, exp);
      end
      if (c == 1) begin
        checks++;
        if (o1_addr !== 32'h10 || o1_size !== 3'd2) begin
          errors++;
          $display("FAIL cpu_load_addr: addr=%h size=%0d required 10 size 2", o1_addr, o1_size);
        end
      end
      if (c == 2) begin
        checks++;
        if (o1_rdata !== 32'hCAFEF00D || o1_addr !== 0) begin
          errors++;
          $display("FAIL cpu_load_rdata: rdata=%h addr=%h required cafef00d addr 0", o1_rdata, o1_addr);
        end
      end
      next_cycle();
    end
    cpu_req = 0;
  endtask

  task automatic test_dbg_store();
    logic [4:0]  exp;
    logic [31:0] exp_addr;
    do_reset();
    next_cycle();
    dbg_req = 1; dbg_wr = 1; dbg_addr = 32'h20; dbg_wdata = 32'h55; dbg_size = 3'd2;
    mem_rdata = 32'hDEADBEEF;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      exp = {c == 1, 1'b0, c == 4, 1'b0, 1'b0};
      exp_addr = (c >= 1 && c <= 3) ? 32'h20 : 32'h0;
      checks++;
      if ({o3_wr_en, o3_rd_en, o3_dbg_done, o3_cpu_done, o3_stall} !== exp || o3_addr !== exp_addr) begin
        errors++;
        $display("FAIL dbg_store_c%0d: wr/rd/dd/cd/stall=%b addr=%h required %b addr=%h",
                 c, {o3_wr_en, o3_rd_en, o3_dbg_done, o3_cpu_done, o3_stall}, o3_addr, exp, exp_addr);
      end
      if (c == 2) begin
        checks++;
        if (o3_wdata !== 32'h55 || o3_size !== 3'd2) begin
          errors++;
          $display("FAIL dbg_store_payload: wdata=%h size=%0d required 55 size 2", o3_wdata, o3_size);
        end
      end
      if (c == 4) begin
        checks++;
        if (o3_rdata !== 32'h0) begin
          errors++;
          $display("FAIL dbg_store_rdata: rdata=%h required 0", o3_rdata);
        end
      end
      next_cycle();
    end
    dbg_req = 0;
  endtask

  task automatic test_tie();
    logic [2:0] exp_seq;
    logic [2:0] got_seq;
    int n;
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = 3'b010;
`else
    exp_seq = 3'b000;
`endif
    got_seq = 3'b000;
    n = 0;
    next_cycle();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h100;
    dbg_req = 1; dbg_wr = 0; dbg_addr = 32'h200;
    mem_rdata = 32'h0BADF00D;
    for (int c = 0; c < 15 && n < 3; c++) begin
      @(negedge clk);
      if (o1_cpu_done || o1_dbg_done) begin
        checks++;
        if ((o1_cpu_done && o1_dbg_done) || o1_stall !== !o1_cpu_done ||
            o1_rdata !== 32'h0BADF00D) begin
          errors++;
          $display("FAIL tie_done_c%0d: cd=%b dd=%b stall=%b rdata=%h required one done, stall=!cd, rdata 0badf00d",
                   c, o1_cpu_done, o1_dbg_done, o1_stall, o1_rdata);
        end
        got_seq[n] = o1_dbg_done;
        n++;
      end
      next_cycle();
    end
    checks++;
    if (n != 3 || got_seq !== exp_seq) begin
      errors++;
      $display("FAIL tie_grants: count=%0d seq(bit0 first,1=dbg)=%b required 3 grants seq=%b",
               n, got_seq, exp_seq);
    end
    cpu_req = 0; dbg_req = 0;
  endtask

  task automatic test_cpu_wait();
    logic [3:0]  exp;
    logic [31:0] exp_addr;
    do_reset();
    next_cycle();
    dbg_req = 1; dbg_wr = 0; dbg_addr = 32'h60;
    mem_rdata = 32'h11112222;
    for (int c = 0; c <= 9; c++) begin
      if (c == 1) begin
        cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h40;
      end
      if (c == 5) dbg_req = 0;
      @(negedge clk);
      exp = {c >= 1 && c <= 8, c == 4, c == 9, c == 1 || c == 6};
      exp_addr = (c >= 1 && c <= 3) ? 32'h60 : (c >= 6 && c <= 8) ? 32'h40 : 32'h0;
      checks++;
      if ({o3_stall, o3_dbg_done, o3_cpu_done, o3_rd_en} !== exp || o3_addr !== exp_addr ||
          o3_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL cpu_wait_c%0d: stall/dd/cd/rd=%b addr=%h wr=%b required %b addr=%h wr=0",
                 c, {o3_stall, o3_dbg_done, o3_cpu_done, o3_rd_en}, o3_addr, o3_wr_en, exp, exp_addr);
      end
      next_cycle();
    end
    cpu_req = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_cycle();
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h30; cpu_wdata = 32'hAA; cpu_size = 3'd1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (o3_wr_en !== 1'b1 || o3_addr !== 32'h30 || o3_wdata !== 32'hAA) begin
      errors++;
      $display("FAIL reset_mid_pre: wr=%b addr=%h wdata=%h required 1 30 aa", o3_wr_en, o3_addr, o3_wdata);
    end
    #1;
    reset = 1;
    cpu_req = 0;
    #1;
    checks++;
    if (o3_wr_en !== 1'b0 || o3_addr !== 0 || o3_wdata !== 0 || o3_size !== 0) begin
      errors++;
      $display("FAIL reset_mid_drop: wr=%b addr=%h wdata=%h size=%0d required all 0",
               o3_wr_en, o3_addr, o3_wdata, o3_size);
    end
    next_cycle();
    reset = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({o3_cpu_done, o3_dbg_done, o3_wr_en, o3_rd_en} !== 4'b0 || o3_addr !== 0) begin
        errors++;
        $display("FAIL reset_mid_after_c%0d: cd/dd/wr/rd=%b addr=%h required 0000 addr 0",
                 c, {o3_cpu_done, o3_dbg_done, o3_wr_en, o3_rd_en}, o3_addr);
      end
      next_cycle();
    end
  endtask

  task automatic test_payload_change();
    logic [31:0] exp_addr;
    do_reset();
    next_cycle();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h50; cpu_size = 3'd2;
    mem_rdata = 32'h12345678;
    for (int c = 0; c <= 4; c++) begin
      if (c == 2) begin
        cpu_req = 0; cpu_addr = 32'h99; cpu_size = 3'd0;
      end
      @(negedge clk);
      exp_addr = (c >= 1 && c <= 3) ? 32'h50 : 32'h0;
      checks++;
      if (o3_addr !== exp_addr || o3_cpu_done !== (c == 4) || o3_stall !== (c < 2)) begin
        errors++;
        $display("FAIL payload_c%0d: addr=%h cd=%b stall=%b required addr=%h cd=%b stall=%b",
                 c, o3_addr, o3_cpu_done, o3_stall, exp_addr, c == 4, c < 2);
      end
      if (c == 4) begin
        checks++;
        if (o3_rdata !== 32'h12345678) begin
          errors++;
          $display("FAIL payload_rdata: rdata=%h required 12345678", o3_rdata);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    reset = 0;
    test_reset();
    test_cpu_load();
    test_dbg_store();
    test_tie();
    test_cpu_wait();
    test_reset_mid();
    test_payload_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning cycles from memory strobe to valid mem_rdata (legal 1..15).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports cpu_req/cpu_wr  in  1 each  pipeline request; 1=store, 0=load.
REQ-005 SHALL have ports cpu_addr/cpu_wdata  in  32 each and cpu_size  in  3  pipeline access address, store data, size code.
REQ-006 SHALL have ports dbg_req/dbg_wr  in  1 each, dbg_addr/dbg_wdata  in  32 each, dbg_size  in  3  debug-port request, same meaning.
REQ-007 SHALL have ports cpu_done/dbg_done  out  1 each  one-cycle completion pulse per requester.
REQ-008 SHALL have port rdata  out  32  load data, valid only while a done is high.
REQ-009 SHALL have port stall  out  1  freezes PC and pipeline registers.
REQ-010 SHALL have ports mem_wr_en/mem_rd_en  out  1 each, mem_addr/mem_wdata  out  32 each, mem_size  out  3  data-memory strobes and payload.
REQ-011 SHALL have port mem_rdata  in  32  data-memory read data.

Function
REQ-012 SHALL implement states IDLE, CPU_ACC, DBG_ACC, RESP.
REQ-013 In IDLE with any request high, SHALL latch the winner's wr/addr/wdata/size and enter the matching ACC state next edge; no request: stay IDLE.
REQ-014 SHALL assert exactly one of mem_wr_en/mem_rd_en for only the first ACC cycle; mem_addr/mem_wdata/mem_size SHALL hold latched values throughout ACC and be zero otherwise.
REQ-015 SHALL remain in ACC for exactly MEM_LAT cycles, counted by a 4-bit counter cleared on ACC entry, then enter RESP.
REQ-016 In RESP (one cycle) SHALL pulse the granted requester's done, drive rdata=mem_rdata for loads and zero for stores, and return to IDLE.
REQ-017 Request-to-done latency SHALL be MEM_LAT+1 cycles; one access SHALL be in flight at a time.
REQ-018 Requesters SHALL hold req and payload until done; deassertion mid-access SHALL NOT abort it; req high in IDLE after done is a new request.
REQ-019 Payload changes during ACC SHALL NOT affect the access in flight.
REQ-020 stall SHALL equal cpu_req AND NOT cpu_done (combinational), including while debug holds the memory.
REQ-021 A request arriving in ACC or RESP SHALL wait in IDLE; simultaneous requests resolved per REQ-025.

Reset
REQ-022 On reset assertion SHALL immediately enter IDLE, clear counter, latched payload, and last-grant flag, and drive all outputs 0 except stall (per REQ-020).
REQ-023 Reset mid-access SHALL drop strobes at once and produce no done for the aborted access.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN SHALL select the tie-break policy.
REQ-025 Defined: on simultaneous requests in IDLE, grant the requester not granted last (flag initial value = debug, so CPU wins first tie); undefined: CPU always wins ties, no last-grant flag is built.

Verification
REQ-026 MEM_LAT=1, CPU load addr 0x10, mem_rdata=0xCAFEF00D -> mem_rd_en cycle 1, cpu_done and rdata=0xCAFEF00D cycle 2, stall high cycles 0-1.
REQ-027 MEM_LAT=3, debug store 0x20/0x55 size 2 -> mem_wr_en only in cycle 1, dbg_done cycle 4, rdata=0, stall low throughout.
REQ-028 CPU and debug both request continuously, macro undefined -> only CPU granted; macro defined -> grants alternate CPU, DBG, CPU.
REQ-029 CPU request while debug in ACC -> stall high until CPU done, CPU access starts in IDLE after debug RESP.
REQ-030 Reset asserted in ACC cycle 1 of a store -> strobes drop same cycle, no done, IDLE after release.
REQ-031 cpu_req dropped and cpu_addr changed mid-ACC -> original address held, cpu_done still pulses.
